timing_sequencer: RTL and testbench

Owns the sequence counter (SC) of the basic computer and produces the one-hot timing signals T0–T15 that the control unit decodes. Also sequences machine start-up and run control: a boot phase after reset, then halted / run / single-instruction step, gated by the S (start) flip-flop. Sits between the external run-control inputs and the control unit's `timer_in`, consuming the control unit's `sc_clear_out`.

---
 rtl/mano_pkg.sv | 11 +
 rtl/timing_sequencer_one_hot_decoder.sv | 15 +
 rtl/timing_sequencer.sv | 79 +++++++
 tb/tb_timing_sequencer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mano_pkg.sv
// Shared types for the basic-computer control path: sequencer states and SC width.
package mano_pkg;
  localparam int SC_WIDTH = 4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    HALTED = 2'd1,
    RUN    = 2'd2,
    STEP   = 2'd3
  } sequencer_state_t;
endpackage

// File: rtl/timing_sequencer_one_hot_decoder.sv
// Binary-to-one-hot decoder with enable; all-zero output when disabled.
module one_hot_decoder #(
  parameter int IN_W = 4
) (
  input  logic [IN_W-1:0]       sel,
  input  logic                  enable,
  output logic [(1<<IN_W)-1:0]  one_hot
);
  localparam int OUT_W = 1 << IN_W;

  always_comb begin
    one_hot = '0;
    if (enable) one_hot = OUT_W'(1) << sel;
  end
endmodule

// File: rtl/timing_sequencer.sv
// Sequence counter and T0..T15 generation plus boot / halted / run / step control.
module timing_sequencer
  import mano_pkg::*;
#(
  parameter int BOOT_CYCLES = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   sc_clear_in,
  input  logic                   s_in,
  input  logic                   run_request_in,
  input  logic                   step_request_in,
  input  logic                   halt_request_in,
  output logic [15:0]            timer_out,
  output logic [SC_WIDTH-1:0]    sc_out,
  output logic                   boot_out,
  output logic                   start_out,
  output logic                   halted_out,
  output logic [COUNT_WIDTH-1:0] retired_out
);
  sequencer_state_t    state, next_state;
  logic [7:0]          boot_cnt;
  logic [SC_WIDTH-1:0] sc;
  logic                halt_pend;
  logic                executing, boundary, halt_eff;

  always_comb begin
    next_state = state;
    start_out  = 1'b0;
    executing  = ((state == RUN) || (state == STEP)) && s_in;
    boundary   = executing && sc_clear_in;
    // A halt request in the boundary cycle itself still stops at that boundary.
    halt_eff   = halt_pend || halt_request_in;
    case (state)
      BOOT:   if (boot_cnt == 8'd0) next_state = HALTED;
      HALTED: begin
        if (run_request_in) begin
          next_state = RUN;
          start_out  = 1'b1;
        end else if (step_request_in) begin
          next_state = STEP;
          start_out  = 1'b1;
        end
      end
      RUN:    if (!s_in || (sc_clear_in && halt_eff)) next_state = HALTED;
      STEP:   if (!s_in || sc_clear_in) next_state = HALTED;
      default: next_state = BOOT;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state       <= BOOT;
      boot_cnt    <= 8'(BOOT_CYCLES - 1);
      sc          <= '0;
      retired_out <= '0;
      halt_pend   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == BOOT && boot_cnt != 8'd0) boot_cnt <= boot_cnt - 8'd1;
      if (executing) sc <= sc_clear_in ? '0 : sc + 1'b1;
      else           sc <= '0;
      if (boundary) retired_out <= retired_out + 1'b1;
      if (next_state == HALTED)                     halt_pend <= 1'b0;
      else if (state == RUN && halt_request_in)     halt_pend <= 1'b1;
    end
  end

  assign sc_out     = sc;
  assign boot_out   = (state == BOOT);
  assign halted_out = (state == HALTED);

  one_hot_decoder #(.IN_W(SC_WIDTH)) u_dec (
    .sel     (sc),
    .enable  (executing),
    .one_hot (timer_out)
  );
endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench: stimulus pushes hand-computed expected outputs, a negedge monitor pops and compares.
module tb_timing_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sc_clear = 1'b0, s = 1'b0, run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
  logic [15:0] timer;
  logic [3:0]  sc;
  logic        boot, start, halted;
  logic [15:0] retired;

  typedef struct {
    logic [15:0] timer;
    logic [3:0]  sc;
    logic        boot, start, halted;
    logic [15:0] retired;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0;

  always #5 clk = ~clk;

  timing_sequencer #(.BOOT_CYCLES(4), .COUNT_WIDTH(16)) dut (
    .clock_in        (clk),
    .reset_in        (rst),
    .sc_clear_in     (sc_clear),
    .s_in            (s),
    .run_request_in  (run_req),
    .step_request_in (step_req),
    .halt_request_in (halt_req),
    .timer_out       (timer),
    .sc_out          (sc),
    .boot_out        (boot),
    .start_out       (start),
    .halted_out      (halted),
    .retired_out     (retired)
  );

  // One clock cycle of stimulus with the outputs expected during that cycle.
  task automatic cyc(input logic r, rn, st, hl, sv, clr,
                     input logic [15:0] et, input logic [3:0] esc,
                     input logic eb, es, eh, input logic [15:0] er);
    exp_t e;
    @(posedge clk); #1;
    rst = r; run_req = rn; step_req = st; halt_req = hl; s = sv; sc_clear = clr;
    e.timer = et; e.sc = esc; e.boot = eb; e.start = es; e.halted = eh; e.retired = er;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (timer !== e.timer || sc !== e.sc || boot !== e.boot || start !== e.start ||
            halted !== e.halted || retired !== e.retired) begin
          fails++;
          $display("FAIL cycle%0d: got timer=%h sc=%0d boot=%b start=%b halted=%b retired=%0d, want timer=%h sc=%0d boot=%b start=%b halted=%b retired=%0d",
                   tests, timer, sc, boot, start, halted, retired,
                   e.timer, e.sc, e.boot, e.start, e.halted, e.retired);
        end
      end
    end
  end

  initial begin : stim
    // reset held
    cyc(1,0,0,0,0,0, 16'h0000,0, 1,0,0, 0);
    cyc(1,0,0,0,1,1, 16'h0000,0, 1,0,0, 0);
    // boot: exactly 4 cycles, requests ignored
    cyc(0,1,0,0,1,0, 16'h0000,0, 1,0,0, 0);
    cyc(0,0,1,1,1,1, 16'h0000,0, 1,0,0, 0);
    cyc(0,1,0,0,1,0, 16'h0000,0, 1,0,0, 0);
    cyc(0,0,0,0,1,0, 16'h0000,0, 1,0,0, 0);
    // halted: halt and sc_clear ignored
    cyc(0,0,0,1,1,1, 16'h0000,0, 0,0,1, 0);
    // run start, boundary at T3
    cyc(0,1,0,0,1,0, 16'h0000,0, 0,1,1, 0);
    cyc(0,0,0,0,1,0, 16'h0001,0, 0,0,0, 0);
    cyc(0,0,0,0,1,0, 16'h0002,1, 0,0,0, 0);
    cyc(0,0,0,0,1,0, 16'h0004,2, 0,0,0, 0);
    cyc(0,0,0,0,1,1, 16'h0008,3, 0,0,0, 0);
    // no clear for 16 cycles: SC runs 0..15 then wraps
    for (int i = 0; i < 16; i++)
      cyc(0,0,0,0,1,0, 16'(1 << i), 4'(i), 0,0,0, 1);
    // wrapped back to T0; halt requested at T1, boundary at T4
    cyc(0,0,0,0,1,0, 16'h0001,0, 0,0,0, 1);
    cyc(0,0,0,1,1,0, 16'h0002,1, 0,0,0, 1);
    cyc(0,0,0,0,1,0, 16'h0004,2, 0,0,0, 1);
    cyc(0,0,0,0,1,0, 16'h0008,3, 0,0,0, 1);
    cyc(0,0,0,0,1,1, 16'h0010,4, 0,0,0, 1);
    // step+run together: must enter RUN (keeps executing past a boundary)
    cyc(0,1,1,0,1,0, 16'h0000,0, 0,1,1, 2);
    cyc(0,0,0,0,1,1, 16'h0001,0, 0,0,0, 2);
    // halt in the boundary cycle itself stops at that boundary
    cyc(0,0,0,1,1,1, 16'h0001,0, 0,0,0, 3);
    // step alone, boundary at T5
    cyc(0,0,1,0,1,0, 16'h0000,0, 0,1,1, 4);
    cyc(0,0,0,0,1,0, 16'h0001,0, 0,0,0, 4);
    cyc(0,0,0,0,1,0, 16'h0002,1, 0,0,0, 4);
    cyc(0,0,0,0,1,0, 16'h0004,2, 0,0,0, 4);
    cyc(0,0,0,0,1,0, 16'h0008,3, 0,0,0, 4);
    cyc(0,0,0,0,1,0, 16'h0010,4, 0,0,0, 4);
    cyc(0,0,0,0,1,1, 16'h0020,5, 0,0,0, 4);
    cyc(0,0,0,0,1,0, 16'h0000,0, 0,0,1, 5);
    // run then s_in drops at T2
    cyc(0,1,0,0,1,0, 16'h0000,0, 0,1,1, 5);
    cyc(0,0,0,0,1,0, 16'h0001,0, 0,0,0, 5);
    cyc(0,0,0,0,1,0, 16'h0002,1, 0,0,0, 5);
    cyc(0,0,0,0,0,1, 16'h0000,2, 0,0,0, 5);
    cyc(0,0,0,0,1,0, 16'h0000,0, 0,0,1, 5);
    // run then reset mid-instruction
    cyc(0,1,0,0,1,0, 16'h0000,0, 0,1,1, 5);
    cyc(0,0,0,0,1,0, 16'h0001,0, 0,0,0, 5);
    cyc(0,0,0,0,1,0, 16'h0002,1, 0,0,0, 5);
    cyc(1,0,0,0,1,0, 16'h0000,0, 1,0,0, 0);
    for (int i = 0; i < 4; i++)
      cyc(0,0,0,0,1,0, 16'h0000,0, 1,0,0, 0);
    cyc(0,0,0,0,1,0, 16'h0000,0, 0,0,1, 0);
    repeat (3) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
